// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size/state encodings and byte-enable helpers for mem_access_unit
package mem_access_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} size_e;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic aligned(size_e s, logic [1:0] off);
    return s == SZ_BYTE || (s == SZ_HALF && !off[0]) || (s == SZ_WORD && off == 2'd0);
  endfunction
  function automatic logic [3:0] be_base(size_e s);
    return s == SZ_BYTE ? BE_BYTE : s == SZ_HALF ? BE_HALF : BE_WORD;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: shifts a bus word down to its byte lane and sign/zero-extends it
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        zero_ext,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = rdata >> {offset, 3'b000};
  assign data = size == SZ_BYTE ? {{24{!zero_ext && sh[7]}}, sh[7:0]} :
                size == SZ_HALF ? {{16{!zero_ext && sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store bridge from core to a ready-handshake bus
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_ren,
  output logic              Bus_wen,
  output logic [3:0]        Bus_be,
  output logic [31:0]       Bus_wdata,
  input  logic [31:0]       Bus_rdata,
  input  logic              Bus_ready
);
  state_e state;
  logic [TO_W-1:0] cnt;
  logic we, zero_ext;
  size_e size, req_sz;
  logic [1:0] off;
  logic [31:0] ext;
  assign req_sz = size_e'(req_size);
  load_align u_align (.rdata(Bus_rdata), .offset(off), .size(size), .zero_ext(zero_ext), .data(ext));
  assign stall = (state == IDLE && req_valid) || state == BUS;
  assign rsp_valid = state == RESP;
  assign Bus_ren = state == BUS && !we;
  assign Bus_wen = state == BUS && we;
  always_ff @(posedge cpu_clk)
    if (cpu_rst) begin
      state <= IDLE;
      cnt <= '0;
      we <= 1'b0;
      size <= SZ_BYTE;
      zero_ext <= 1'b0;
      off <= 2'd0;
      Bus_addr <= '0;
      Bus_be <= 4'd0;
      Bus_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          if (aligned(req_sz, req_addr[1:0])) begin
            state <= BUS;
            we <= req_we;
            size <= req_sz;
            zero_ext <= req_unsigned;
            off <= req_addr[1:0];
            Bus_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            Bus_be <= be_base(req_sz) << req_addr[1:0];
            Bus_wdata <= req_sz == SZ_BYTE ? {4{req_wdata[7:0]}} :
                         req_sz == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;
          end else begin
            state <= RESP;
            rsp_err <= 1'b1;
          end
        end
        // ready beats the timeout when both land in the same cycle
        BUS: if (Bus_ready || cnt == TO_W'(TIMEOUT - 1)) begin
          state <= RESP;
          cnt <= '0;
          rsp_err <= !Bus_ready;
          rsp_rdata <= Bus_ready && !we ? ext : 32'd0;
        end else cnt <= cnt + TO_W'(1);
        RESP: begin
          state <= IDLE;
          cnt <= '0;
          rsp_err <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed transactions checked against a transaction-level model
module tb_mem_access_unit;
  localparam int TO = 4;
  logic cpu_clk = 1'b0, cpu_rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic stall, rsp_valid, rsp_err, Bus_ren, Bus_wen;
  logic [31:0] rsp_rdata, Bus_addr, Bus_wdata;
  logic [3:0] Bus_be;
  logic [31:0] Bus_rdata = 32'd0;
  logic Bus_ready = 1'b0;
  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .TO_W(16)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Bus_addr(Bus_addr), .Bus_ren(Bus_ren), .Bus_wen(Bus_wen), .Bus_be(Bus_be),
    .Bus_wdata(Bus_wdata), .Bus_rdata(Bus_rdata), .Bus_ready(Bus_ready)
  );
  always #5 cpu_clk = ~cpu_clk;
  int errors = 0, checks = 0;
  logic run = 1'b0;
  logic m_we, m_legal, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0] m_be;
  int m_issued = 0, m_seen = 0, m_aborted = 0;
  int lat, strobes;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0] cap_be;
  logic cap_err, cap_stall;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  // expected bus/response values derived from the request with plain arithmetic
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int wait_n);
    int a;
    logic [31:0] v;
    a = int'(addr % 4);
    m_we = we;
    m_addr = addr - 32'(a);
    m_legal = size == 2'd0 || (size == 2'd1 && a % 2 == 0) || (size == 2'd2 && a == 0);
    m_be = size == 2'd0 ? 4'(1 << a) : size == 2'd1 ? 4'(3 << a) : 4'hF;
    m_wdata = size == 2'd0 ? (wdata & 32'hFF) * 32'h01010101 :
              size == 2'd1 ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
    v = rdata >> (8 * a);
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    m_err = !m_legal || wait_n < 0 || wait_n >= TO;
    m_rdata = (m_err || we) ? 32'd0 : v;
    m_issued++;
  endtask
  // wait_n: bus cycles before Bus_ready rises; negative = never
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int wait_n);
    model_req(we, size, uns, addr, wdata, rdata, wait_n);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; Bus_rdata = rdata;
    @(posedge cpu_clk); #1;
    req_valid = 1'b0;
    lat = 0; strobes = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      Bus_ready = wait_n >= 0 && c - 1 >= wait_n;
      @(negedge cpu_clk);
      if (Bus_ren || Bus_wen) begin
        if (strobes == 0) begin
          cap_addr = Bus_addr; cap_be = Bus_be; cap_wdata = Bus_wdata;
        end
        strobes++;
      end
      if (rsp_valid) begin
        lat = c; cap_rdata = rsp_rdata; cap_err = rsp_err; cap_stall = stall;
      end
      @(posedge cpu_clk); #1;
    end
    Bus_ready = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL rsp_wait: no rsp_valid within 60 cycles for addr 0x%08h", addr);
    end
  endtask
  always @(negedge cpu_clk)
    if (run && !cpu_rst) begin
      if (Bus_ren || Bus_wen) begin
        chk("strobe_kind", {30'd0, Bus_ren, Bus_wen}, m_legal ? (m_we ? 32'd1 : 32'd2) : 32'd0);
        chk("bus_addr", Bus_addr, m_addr);
        chk("bus_be", {28'd0, Bus_be}, {28'd0, m_be});
        if (m_we) chk("bus_wdata", Bus_wdata, m_wdata);
        chk("stall_bus", {31'd0, stall}, 32'd1);
      end
      if (rsp_valid) begin
        chk("rsp_expected", {31'd0, m_issued > m_seen + m_aborted}, 32'd1);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        chk("stall_resp", {31'd0, stall}, 32'd0);
        m_seen++;
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    req_valid = 1'b1;
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_stall_follows", {31'd0, stall}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_strobes", {30'd0, Bus_ren, Bus_wen}, 32'd0);
    chk("rst_bus_be", {28'd0, Bus_be}, 32'd0);
    chk("rst_bus_addr", Bus_addr, 32'd0);
    chk("rst_bus_wdata", Bus_wdata, 32'd0);
    req_valid = 1'b0;
    #1;
    chk("rst_stall_low", {31'd0, stall}, 32'd0);
    cpu_rst = 1'b0;
    run = 1'b1;
    @(posedge cpu_clk); #1;
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80AABBCC, 0);
    chk("lb_latency", lat, 32'd2);
    chk("lb_be", {28'd0, cap_be}, 32'h8);
    chk("lb_rdata", cap_rdata, 32'hFFFFFF80);
    do_req(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 32'h0, 0);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_err", {31'd0, cap_err}, 32'd0);
    chk("sh_rdata", cap_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h106, 32'h0, 32'h11111111, 0);
    chk("lw_mis_latency", lat, 32'd1);
    chk("lw_mis_strobes", strobes, 32'd0);
    chk("lw_mis_err", {31'd0, cap_err}, 32'd1);
    chk("lw_mis_stall", {31'd0, cap_stall}, 32'd0);
    do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h12348056, 0);
    chk("lbu_rdata", cap_rdata, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h9ABC0000, 0);
    chk("lh_rdata", cap_rdata, 32'hFFFF9ABC);
    do_req(1'b1, 2'd0, 1'b0, 32'h3, 32'h123456A5, 32'h0, 0);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1);
    chk("sw_latency", lat, 32'd3);
    chk("sw_be", {28'd0, cap_be}, 32'hF);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 0);
    chk("size3_err", {31'd0, cap_err}, 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h1234, 32'h0, 0);
    chk("sh_odd_strobes", strobes, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 2);
    chk("lw_wait_latency", lat, 32'd4);
    chk("lw_wait_rdata", cap_rdata, 32'hCAFEF00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h55AA55AA, -1);
    chk("to_strobes", strobes, 32'd4);
    chk("to_latency", lat, 32'd5);
    chk("to_err", {31'd0, cap_err}, 32'd1);
    chk("to_rdata", cap_rdata, 32'd0);
    Bus_ready = 1'b1;
    repeat (3) begin
      @(negedge cpu_clk);
      chk("idle_ready_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("idle_ready_strobe", {30'd0, Bus_ren, Bus_wen}, 32'd0);
      @(posedge cpu_clk); #1;
    end
    Bus_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'h01020304, TO - 1);
    chk("ready_at_to_err", {31'd0, cap_err}, 32'd0);
    chk("ready_at_to_rdata", cap_rdata, 32'h01020304);
    do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h1234F00D, 3);
    chk("lhu_rdata", cap_rdata, 32'h0000F00D);
    chk("lhu_latency", lat, 32'd5);
    model_req(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, 32'h1234F00D, 3);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_unsigned = 1'b1; req_addr = 32'h4;
    @(posedge cpu_clk); #1;
    req_valid = 1'b0;
    @(negedge cpu_clk);
    chk("abort_ren_before", {31'd0, Bus_ren}, 32'd1);
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b1;
    m_aborted++;
    @(posedge cpu_clk); #1;
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    chk("abort_ren_after", {31'd0, Bus_ren}, 32'd0);
    repeat (4) begin
      chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge cpu_clk);
    end
    @(posedge cpu_clk); #1;
    do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0000007F, 0);
    chk("recover_rdata", cap_rdata, 32'h7F);
    chk("recover_latency", lat, 32'd2);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
